// File: rtl/lrwait_qnode_multi.sv
// Multi-slot LRWait/SCWait queue node between a Snitch core and the tile interconnect; requests and responses pass through combinationally.
// Core requests stall while a successor WakeUp is being injected or an LRWait finds no free slot; slot_busy_o and error_o lag one cycle.
module lrwait_qnode_multi #(
    parameter int NumSlots    = 2,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int MetaIdWidth = 6,
    parameter int MetaWidth   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AddrWidth-1:0]     snitch_qaddr_i,
    input  logic                     snitch_qwrite_i,
    input  logic [3:0]               snitch_qamo_i,
    input  logic [DataWidth-1:0]     snitch_qdata_i,
    input  logic [DataWidth/8-1:0]   snitch_qstrb_i,
    input  logic [MetaIdWidth-1:0]   snitch_qid_i,
    input  logic                     snitch_qvalid_i,
    output logic                     snitch_qready_o,
    output logic [DataWidth-1:0]     snitch_pdata_o,
    output logic                     snitch_perror_o,
    output logic [MetaIdWidth-1:0]   snitch_pid_o,
    output logic                     snitch_pvalid_o,
    input  logic                     snitch_pready_i,
    output logic [AddrWidth-1:0]     tile_qaddr_o,
    output logic                     tile_qwrite_o,
    output logic [3:0]               tile_qamo_o,
    output logic [DataWidth-1:0]     tile_qdata_o,
    output logic [DataWidth/8-1:0]   tile_qstrb_o,
    output logic [MetaIdWidth-1:0]   tile_qid_o,
    output logic                     tile_qlrwait_o,
    output logic                     tile_qvalid_o,
    input  logic                     tile_qready_i,
    input  logic [DataWidth-1:0]     tile_pdata_i,
    input  logic                     tile_perror_i,
    input  logic [MetaIdWidth-1:0]   tile_pid_i,
    input  logic                     tile_plrwait_i,
    input  logic                     tile_pvalid_i,
    output logic                     tile_pready_o,
    output logic [NumSlots-1:0]      slot_busy_o,
    output logic                     error_o
);
    localparam int SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam logic [3:0] AmoLrWait = 4'hC;
    localparam logic [3:0] AmoScWait = 4'hD;

    typedef enum logic [2:0] {S_FREE, S_WAIT_RESP, S_RESERVED, S_SC_ISSUED, S_WAKE_UP} slot_state_e;

    slot_state_e            r_state    [NumSlots];
    logic [MetaIdWidth-1:0] r_lr_id    [NumSlots];
    logic [MetaIdWidth-1:0] r_sc_id    [NumSlots];
    logic [AddrWidth-1:0]   r_addr     [NumSlots];
    logic [MetaWidth-1:0]   r_meta     [NumSlots];
    logic [NumSlots-1:0]    r_has_succ;
    logic [SlotW-1:0]       r_rr;
    logic [NumSlots-1:0]    r_busy;
    logic                   r_error;

    slot_state_e            w_state_nxt    [NumSlots];
    logic [MetaIdWidth-1:0] w_lr_id_nxt    [NumSlots];
    logic [MetaIdWidth-1:0] w_sc_id_nxt    [NumSlots];
    logic [AddrWidth-1:0]   w_addr_nxt     [NumSlots];
    logic [MetaWidth-1:0]   w_meta_nxt     [NumSlots];
    logic [NumSlots-1:0]    w_has_succ_nxt;
    logic [SlotW-1:0]       w_rr_nxt;
    logic [NumSlots-1:0]    w_busy_nxt;
    logic                   w_err;

    logic             w_wake_any, w_free_any;
    logic [SlotW-1:0] w_win;
    logic             w_is_lrw, w_is_scw, w_core_hs, w_succ_upd, w_rsp_hs;
    logic             w_succ_done, w_rsp_done, w_sc_done, w_alloc_done;

    function automatic logic [SlotW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NumSlots) s = s - NumSlots;
        return SlotW'(s);
    endfunction

    assign w_is_lrw   = snitch_qvalid_i && (snitch_qamo_i == AmoLrWait);
    assign w_is_scw   = snitch_qvalid_i && (snitch_qamo_i == AmoScWait);
    assign w_core_hs  = snitch_qvalid_i && snitch_qready_o;
    assign w_succ_upd = tile_pvalid_i && tile_plrwait_i;
    assign w_rsp_hs   = tile_pvalid_i && !tile_plrwait_i && snitch_pready_i;

    // Round-robin pick: first WakeUp slot at or after the pointer.
    always_comb begin
        w_wake_any = 1'b0;
        w_win      = '0;
        w_free_any = 1'b0;
        for (int k = 0; k < NumSlots; k++) begin
            if (!w_wake_any && r_state[wrap_idx(int'(r_rr), k)] == S_WAKE_UP) begin
                w_wake_any = 1'b1;
                w_win      = wrap_idx(int'(r_rr), k);
            end
            if (r_state[k] == S_FREE) w_free_any = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSlots; i++) begin
                r_state[i] <= S_FREE;
                r_lr_id[i] <= '0;
                r_sc_id[i] <= '0;
                r_addr[i]  <= '0;
                r_meta[i]  <= '0;
            end
            r_has_succ <= '0;
            r_rr       <= '0;
            r_busy     <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lr_id    <= w_lr_id_nxt;
            r_sc_id    <= w_sc_id_nxt;
            r_addr     <= w_addr_nxt;
            r_meta     <= w_meta_nxt;
            r_has_succ <= w_has_succ_nxt;
            r_rr       <= w_rr_nxt;
            r_busy     <= w_busy_nxt;
            r_error    <= w_err;
        end
    end

    // All matching uses current-cycle state, so a slot freed now is not reused until next cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_lr_id_nxt    = r_lr_id;
        w_sc_id_nxt    = r_sc_id;
        w_addr_nxt     = r_addr;
        w_meta_nxt     = r_meta;
        w_has_succ_nxt = r_has_succ;
        w_rr_nxt       = r_rr;
        w_err          = 1'b0;
        w_succ_done    = 1'b0;
        w_rsp_done     = 1'b0;
        w_sc_done      = 1'b0;
        w_alloc_done   = 1'b0;
        if (w_core_hs && w_is_lrw) begin
            for (int i = 0; i < NumSlots; i++)
                if (r_state[i] != S_FREE && r_addr[i] == snitch_qaddr_i) w_err = 1'b1;
        end
        if (w_succ_upd) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (!w_succ_done && r_state[i] != S_FREE && r_lr_id[i] == tile_pid_i) begin
                    w_succ_done = 1'b1;
                    if (r_state[i] != S_WAKE_UP) begin
                        w_meta_nxt[i]     = tile_pdata_i[MetaWidth-1:0];
                        w_has_succ_nxt[i] = 1'b1;
                        if (r_state[i] == S_SC_ISSUED) w_state_nxt[i] = S_WAKE_UP;
                    end
                end
            end
            if (!w_succ_done) w_err = 1'b1;
        end
        if (w_rsp_hs) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (!w_rsp_done && r_state[i] == S_WAIT_RESP && r_lr_id[i] == tile_pid_i) begin
                    w_rsp_done     = 1'b1;
                    w_state_nxt[i] = S_RESERVED;
                end else if (!w_rsp_done && r_state[i] == S_SC_ISSUED && r_sc_id[i] == tile_pid_i) begin
                    w_rsp_done     = 1'b1;
                    w_state_nxt[i] = S_FREE;
                end
            end
        end
        if (w_core_hs && w_is_scw) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (!w_sc_done && r_state[i] == S_RESERVED && r_addr[i] == snitch_qaddr_i) begin
                    w_sc_done      = 1'b1;
                    w_sc_id_nxt[i] = snitch_qid_i;
                    w_state_nxt[i] = w_has_succ_nxt[i] ? S_WAKE_UP : S_SC_ISSUED;
                end
            end
            if (!w_sc_done) w_err = 1'b1;
        end
        if (w_core_hs && w_is_lrw) begin
            for (int i = 0; i < NumSlots; i++) begin
                if (!w_alloc_done && r_state[i] == S_FREE) begin
                    w_alloc_done      = 1'b1;
                    w_lr_id_nxt[i]    = snitch_qid_i;
                    w_addr_nxt[i]     = snitch_qaddr_i;
                    w_has_succ_nxt[i] = 1'b0;
                    w_state_nxt[i]    = S_WAIT_RESP;
                end
            end
        end
        if (w_wake_any && tile_qready_i) begin
            w_state_nxt[w_win] = S_FREE;
            w_rr_nxt           = wrap_idx(int'(w_win), 1);
        end
        for (int i = 0; i < NumSlots; i++) w_busy_nxt[i] = (w_state_nxt[i] != S_FREE);
    end

    always_comb begin
        tile_qaddr_o    = snitch_qaddr_i;
        tile_qwrite_o   = snitch_qwrite_i;
        tile_qamo_o     = snitch_qamo_i;
        tile_qdata_o    = snitch_qdata_i;
        tile_qstrb_o    = snitch_qstrb_i;
        tile_qid_o      = snitch_qid_i;
        tile_qlrwait_o  = 1'b0;
        tile_qvalid_o   = snitch_qvalid_i;
        snitch_qready_o = tile_qready_i;
        if (w_wake_any) begin
            tile_qaddr_o    = r_addr[w_win];
            tile_qwrite_o   = 1'b0;
            tile_qamo_o     = AmoLrWait;
            tile_qdata_o    = DataWidth'(r_meta[w_win]);
            tile_qstrb_o    = '0;
            tile_qid_o      = r_lr_id[w_win];
            tile_qlrwait_o  = 1'b1;
            tile_qvalid_o   = 1'b1;
            snitch_qready_o = 1'b0;
        end else if (w_is_lrw && !w_free_any) begin
            tile_qvalid_o   = 1'b0;
            snitch_qready_o = 1'b0;
        end
    end

    assign snitch_pdata_o  = tile_pdata_i;
    assign snitch_perror_o = tile_perror_i;
    assign snitch_pid_o    = tile_pid_i;
    assign snitch_pvalid_o = tile_pvalid_i && !tile_plrwait_i;
    assign tile_pready_o   = tile_plrwait_i ? 1'b1 : snitch_pready_i;
    assign slot_busy_o     = r_busy;
    assign error_o         = r_error;
endmodule
